// File: rtl/ultrasonic_ranger.sv
// ****************************************************************************
// * ultrasonic_ranger: alternating front/side ultrasonic rangefinder with    *
// * echo-width to centimetre conversion and held per-channel distances.      *
// * Optional feature macro: RANGER_MEDIAN3_EN (median-of-3 output filter).   *
// * Revision: 1.0                                                            *
// ****************************************************************************
`default_nettype none

module ultrasonic_ranger #(
  parameter int CYC_PER_CM       = 2900,
  parameter int TRIG_CYC         = 500,
  parameter int ECHO_TIMEOUT_CYC = 1500000,
  parameter int SLOT_CYC         = 3000000,
  parameter int MAX_CM           = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       echo_q,
  input  logic       echo_z,
  output logic       trig_q,
  output logic       trig_z,
  output logic [9:0] hq,
  output logic [9:0] hz,
  output logic       vld_q,
  output logic       vld_z
);

  localparam logic [9:0]  c_MAX_CM    = 10'(MAX_CM);
  localparam logic [11:0] c_PRE_LAST  = 12'(CYC_PER_CM - 1);
  localparam logic [21:0] c_TRIG_LAST = 22'(TRIG_CYC - 1);
  localparam logic [21:0] c_TO_LAST   = 22'(ECHO_TIMEOUT_CYC - 1);
  localparam logic [21:0] c_SLOT_LAST = 22'(SLOT_CYC - 1);

  localparam logic [1:0] S_TRIG      = 2'd0;
  localparam logic [1:0] S_WAIT_RISE = 2'd1;
  localparam logic [1:0] S_MEASURE   = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_chan;
  logic [21:0] r_slot_cnt;
  logic [21:0] r_wait_cnt;
  logic [11:0] r_presc;
  logic [9:0]  r_cm;
  logic        r_q_meta, r_q_sync, r_q_dly;
  logic        r_z_meta, r_z_sync, r_z_dly;
  logic        r_trig_q, r_trig_z;
  logic [9:0]  r_hq, r_hz;
  logic        r_vld_q, r_vld_z;

  logic        w_echo_s, w_echo_d, w_rise, w_fall;
  logic        w_presc_wrap, w_timeout, w_slot_end;
  logic [9:0]  w_cm_inc, w_cm_step;
  logic        w_done;
  logic [9:0]  w_result;
  logic        w_trig_q_nxt, w_trig_z_nxt;

  // 2-flop synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_meta <= 1'b0;
      r_q_sync <= 1'b0;
      r_q_dly  <= 1'b0;
      r_z_meta <= 1'b0;
      r_z_sync <= 1'b0;
      r_z_dly  <= 1'b0;
    end else begin
      r_q_meta <= echo_q;
      r_q_sync <= r_q_meta;
      r_q_dly  <= r_q_sync;
      r_z_meta <= echo_z;
      r_z_sync <= r_z_meta;
      r_z_dly  <= r_z_sync;
    end
  end

  assign w_echo_s     = r_chan ? r_z_sync : r_q_sync;
  assign w_echo_d     = r_chan ? r_z_dly  : r_q_dly;
  assign w_rise       = w_echo_s & ~w_echo_d;
  assign w_fall       = ~w_echo_s & w_echo_d;
  assign w_presc_wrap = (r_presc == c_PRE_LAST);
  assign w_timeout    = (r_wait_cnt == c_TO_LAST);
  assign w_slot_end   = (r_state == S_HOLD) && (r_slot_cnt == c_SLOT_LAST);
  assign w_cm_inc     = (r_cm == c_MAX_CM) ? r_cm : r_cm + 10'd1;
  // cm including the current cycle, so the fall cycle itself is counted
  assign w_cm_step    = w_presc_wrap ? w_cm_inc : r_cm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_TRIG;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_result = c_MAX_CM;
    case (r_state)
      S_TRIG: begin
        if (r_slot_cnt == c_TRIG_LAST) w_next = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_next = S_MEASURE;
        end else if (w_timeout) begin
          w_done = 1'b1;
          w_next = S_HOLD;
        end
      end
      S_MEASURE: begin
        if (w_fall) begin
          w_done   = 1'b1;
          w_result = (w_cm_step == 10'd0) ? 10'd1 : w_cm_step;
          w_next   = S_HOLD;
        end else if (w_timeout) begin
          w_done = 1'b1;
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_slot_cnt == c_SLOT_LAST) w_next = S_TRIG;
      end
      default: w_next = S_TRIG;
    endcase
  end

  always_comb begin
    w_trig_q_nxt = (r_state == S_TRIG) && !r_chan;
    w_trig_z_nxt = (r_state == S_TRIG) &&  r_chan;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chan     <= 1'b0;
      r_slot_cnt <= 22'd0;
      r_wait_cnt <= 22'd0;
      r_presc    <= 12'd0;
      r_cm       <= 10'd0;
      r_trig_q   <= 1'b0;
      r_trig_z   <= 1'b0;
    end else begin
      r_trig_q <= w_trig_q_nxt;
      r_trig_z <= w_trig_z_nxt;
      if (w_slot_end) begin
        r_slot_cnt <= 22'd0;
        r_chan     <= ~r_chan;
      end else if (r_slot_cnt != c_SLOT_LAST) begin
        r_slot_cnt <= r_slot_cnt + 22'd1;
      end
      // wait counter doubles as the echo high-time counter in MEASURE
      if ((r_state == S_TRIG) || ((r_state == S_WAIT_RISE) && w_rise)) begin
        r_wait_cnt <= 22'd0;
      end else if (((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 22'd1;
      end
      if (r_state == S_WAIT_RISE) begin
        r_presc <= 12'd0;
        r_cm    <= 10'd0;
      end else if (r_state == S_MEASURE) begin
        r_presc <= w_presc_wrap ? 12'd0 : r_presc + 12'd1;
        r_cm    <= w_cm_step;
      end
    end
  end

`ifdef RANGER_MEDIAN3_EN
  logic [9:0] r_hq0, r_hq1, r_hq2, r_hz0, r_hz1, r_hz2;
  logic [1:0] r_nq, r_nz;
  logic       r_pend_q, r_pend_z;

  function automatic logic [9:0] f_med3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
    logic [9:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hq0 <= 10'd0; r_hq1 <= 10'd0; r_hq2 <= 10'd0;
      r_hz0 <= 10'd0; r_hz1 <= 10'd0; r_hz2 <= 10'd0;
      r_nq <= 2'd0; r_nz <= 2'd0;
      r_pend_q <= 1'b0; r_pend_z <= 1'b0;
      r_hq <= 10'd0; r_hz <= 10'd0;
      r_vld_q <= 1'b0; r_vld_z <= 1'b0;
    end else begin
      r_pend_q <= w_done && !r_chan;
      r_pend_z <= w_done &&  r_chan;
      if (w_done && !r_chan) begin
        r_hq0 <= w_result; r_hq1 <= r_hq0; r_hq2 <= r_hq1;
        if (r_nq != 2'd3) r_nq <= r_nq + 2'd1;
      end
      if (w_done && r_chan) begin
        r_hz0 <= w_result; r_hz1 <= r_hz0; r_hz2 <= r_hz1;
        if (r_nz != 2'd3) r_nz <= r_nz + 2'd1;
      end
      // publish one cycle after capture, once the history is settled
      r_vld_q <= r_pend_q;
      r_vld_z <= r_pend_z;
      if (r_pend_q) r_hq <= (r_nq == 2'd3) ? f_med3(r_hq0, r_hq1, r_hq2) : r_hq0;
      if (r_pend_z) r_hz <= (r_nz == 2'd3) ? f_med3(r_hz0, r_hz1, r_hz2) : r_hz0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hq    <= 10'd0;
      r_hz    <= 10'd0;
      r_vld_q <= 1'b0;
      r_vld_z <= 1'b0;
    end else begin
      r_vld_q <= w_done && !r_chan;
      r_vld_z <= w_done &&  r_chan;
      if (w_done && !r_chan) r_hq <= w_result;
      if (w_done &&  r_chan) r_hz <= w_result;
    end
  end
`endif

  assign trig_q = r_trig_q;
  assign trig_z = r_trig_z;
  assign hq     = r_hq;
  assign hz     = r_hz;
  assign vld_q  = r_vld_q;
  assign vld_z  = r_vld_z;

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
// ****************************************************************************
// * tb_ultrasonic_ranger: directed bench for ultrasonic_ranger with scaled   *
// * timing parameters. Honors RANGER_MEDIAN3_EN for expected values.         *
// * Revision: 1.0                                                            *
// ****************************************************************************
`default_nettype none

module tb_ultrasonic_ranger;

  localparam int P_CPC  = 10;
  localparam int P_TRIG = 5;
  localparam int P_TO   = 300;
  localparam int P_SLOT = 400;
  localparam int P_MAX  = 1023;
`ifdef RANGER_MEDIAN3_EN
  localparam int c_LAT   = 4;
  localparam int c_M4_EXP = 7;
`else
  localparam int c_LAT   = 3;
  localparam int c_M4_EXP = 6;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       echo_q = 1'b0;
  logic       echo_z = 1'b0;
  logic       trig_q, trig_z, vld_q, vld_z;
  logic [9:0] hq, hz;

  int n_vec = 0;
  int n_err = 0;

  ultrasonic_ranger #(
    .CYC_PER_CM(P_CPC), .TRIG_CYC(P_TRIG), .ECHO_TIMEOUT_CYC(P_TO),
    .SLOT_CYC(P_SLOT), .MAX_CM(P_MAX)
  ) u_dut (
    .clk(clk), .rst(rst), .echo_q(echo_q), .echo_z(echo_z),
    .trig_q(trig_q), .trig_z(trig_z), .hq(hq), .hz(hz),
    .vld_q(vld_q), .vld_z(vld_z)
  );

  always #5 clk = ~clk;

  // posedge monitor: sees the values held during the cycle just ended
  int         cyc = 0;
  int         n_vld_q = 0, n_vld_z = 0, last_vq_cyc = 0, last_vz_cyc = 0;
  int         last_hq = 0, last_hz = 0;
  int         rise_q = 0, rise_z = 0, len_q = 0, len_z = 0, n_both = 0;
  logic       tq_p = 1'b0, tz_p = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vld_q) begin n_vld_q <= n_vld_q + 1; last_vq_cyc <= cyc; last_hq <= int'(hq); end
    if (vld_z) begin n_vld_z <= n_vld_z + 1; last_vz_cyc <= cyc; last_hz <= int'(hz); end
    if (trig_q) begin len_q <= tq_p ? len_q + 1 : 1; if (!tq_p) rise_q <= cyc; end
    if (trig_z) begin len_z <= tz_p ? len_z + 1 : 1; if (!tz_p) rise_z <= cyc; end
    tq_p <= trig_q;
    tz_p <= trig_z;
    if (trig_q && trig_z) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_echo(input bit ch, input logic v);
    if (ch) echo_z = v;
    else    echo_q = v;
  endtask

  task automatic wait_trig(input bit ch, input logic lvl, input int limit, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((ch ? trig_z : trig_q) === lvl) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check(tag, int'(seen), 1);
  endtask

  // one slot: trigger, optional echo (or a pulse on the other channel), result
  task automatic run_slot(input bit ch, input int dly, input int w, input int xw,
                          input int exp, input bit chk_lat, input bit chk_slot,
                          input string tag);
    int n0, drop;
    n0 = ch ? n_vld_z : n_vld_q;
    wait_trig(ch, 1'b1, 2 * P_SLOT + 10, {tag, "_trig_rise"});
    wait_trig(ch, 1'b0, P_TRIG + 5, {tag, "_trig_fall"});
    check({tag, "_trig_width"}, ch ? len_z : len_q, P_TRIG);
    if (chk_slot) check({tag, "_slot_len"}, ch ? rise_z - rise_q : rise_q - rise_z, P_SLOT);
    repeat (dly) @(negedge clk);
    if (w > 0) begin
      drive_echo(ch, 1'b1);
      repeat (w) @(negedge clk);
      drive_echo(ch, 1'b0);
    end else if (xw > 0) begin
      drive_echo(!ch, 1'b1);
      repeat (xw) @(negedge clk);
      drive_echo(!ch, 1'b0);
    end
    drop = cyc;
    for (int i = 0; i < P_SLOT && (ch ? n_vld_z : n_vld_q) == n0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({tag, "_vld_count"}, (ch ? n_vld_z : n_vld_q) - n0, 1);
    check({tag, "_value"}, ch ? last_hz : last_hq, exp);
    if (chk_lat) check({tag, "_latency"}, (ch ? last_vz_cyc : last_vq_cyc) - drop, c_LAT);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int nz0;
    repeat (3) @(negedge clk);
    check("rst_trig_q", int'(trig_q), 0);
    check("rst_trig_z", int'(trig_z), 0);
    check("rst_hq", int'(hq), 0);
    check("rst_hz", int'(hz), 0);
    check("rst_vld_q", int'(vld_q), 0);
    check("rst_vld_z", int'(vld_z), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_trig_q", int'(trig_q), 1);
    check("rel_trig_z", int'(trig_z), 0);

    run_slot(1'b0, 10, 100, 0, 10, 1'b1, 1'b0, "q10cm");
    check("q10cm_hz_hold", int'(hz), 0);
    run_slot(1'b1, 10, 10, 0, 1, 1'b1, 1'b1, "z_near");
    check("z_near_hq_hold", int'(hq), 10);
    nz0 = n_vld_z;
    run_slot(1'b0, 20, 0, 40, P_MAX, 1'b0, 1'b1, "q_noecho");
    check("q_noecho_z_ignored", n_vld_z - nz0, 0);
    check("q_noecho_hz_hold", int'(hz), 1);
    run_slot(1'b1, 10, 99, 0, 9, 1'b1, 1'b1, "z_floor");
    run_slot(1'b0, 10, 350, 0, P_MAX, 1'b0, 1'b1, "q_stuck");

    // reset during a side-channel measurement
    wait_trig(1'b1, 1'b1, 2 * P_SLOT, "rstm_trig_rise");
    wait_trig(1'b1, 1'b0, P_TRIG + 5, "rstm_trig_fall");
    check("rstm_slot_len", rise_z - rise_q, P_SLOT);
    repeat (5) @(negedge clk);
    echo_z = 1'b1;
    repeat (40) @(negedge clk);
    nz0 = n_vld_z;
    rst = 1'b0;
    #1;
    check("rstm_hq", int'(hq), 0);
    check("rstm_hz", int'(hz), 0);
    check("rstm_trig_z", int'(trig_z), 0);
    check("rstm_vld_z", int'(vld_z), 0);
    echo_z = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstm_restart_q", int'(trig_q), 1);
    check("rstm_restart_z", int'(trig_z), 0);
    check("rstm_no_result", n_vld_z - nz0, 0);

    run_slot(1'b0, 10, 50, 0, 5, 1'b1, 1'b0, "m1_q");
    run_slot(1'b1, 10, 30, 0, 3, 1'b1, 1'b1, "m1_z");
    run_slot(1'b0, 10, 250, 0, 25, 1'b1, 1'b1, "m2_q");
    run_slot(1'b1, 10, 30, 0, 3, 1'b1, 1'b1, "m2_z");
    run_slot(1'b0, 10, 70, 0, 7, 1'b1, 1'b1, "m3_q");
    run_slot(1'b1, 10, 30, 0, 3, 1'b1, 1'b1, "m3_z");
    run_slot(1'b0, 10, 60, 0, c_M4_EXP, 1'b1, 1'b1, "m4_q");
    check("one_trig_at_a_time", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
